// File: rtl/count_sched.sv
// count_sched: round-robin scheduler that lends one shared duration counter to NREQ requesters.
// Define COUNT_SCHED_TIMEOUT_EN to add a 40-cycle RUN watchdog that pulses err.
module count_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] dur,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              err,
  output logic              cnt_clear,
  output logic              cnt_enable,
  output logic [W-1:0]      cnt_max,
  input  logic              cnt_ready
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, win_idx;
  logic [W-1:0]    win_dur;
  logic [NREQ-1:0] win_oh;

  logic            hi_v, lo_v, sel_v;
  logic [IW-1:0]   hi_idx, lo_idx, sel_idx;
  logic [W-1:0]    hi_dur, lo_dur, sel_dur;

  // Round-robin: first requester above the last winner, else the lowest requester (wrap).
  always_comb begin
    hi_v   = 1'b0;
    lo_v   = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    hi_dur = '0;
    lo_dur = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if (!hi_v && (i > 32'(ptr))) begin
          hi_v   = 1'b1;
          hi_idx = IW'(i);
          hi_dur = dur[i*W +: W];
        end
        if (!lo_v) begin
          lo_v   = 1'b1;
          lo_idx = IW'(i);
          lo_dur = dur[i*W +: W];
        end
      end
    end
    sel_v   = lo_v;
    sel_idx = hi_v ? hi_idx : lo_idx;
    sel_dur = hi_v ? hi_dur : lo_dur;
  end

  assign win_oh = NREQ'(1) << win_idx;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      ptr     <= IW'(NREQ - 1);
      win_idx <= '0;
      win_dur <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && sel_v) begin
        win_idx <= sel_idx;
        win_dur <= sel_dur;
        ptr     <= sel_idx;
      end
    end
  end

`ifdef COUNT_SCHED_TIMEOUT_EN
  logic [5:0] wdog;
  logic       err_q;
  logic       timeout;

  // wdog holds the number of RUN cycles already completed; the 40th one times out.
  assign timeout = (state == RUN) && !cnt_ready && (wdog == 6'd39);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state == RUN) wdog <= wdog + 6'd1;
      else              wdog <= '0;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    grant      = '0;
    done       = '0;
    busy       = 1'b0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    cnt_max    = '0;
    case (state)
      IDLE: begin
        if (sel_v) state_nx = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        grant     = win_oh;
        cnt_max   = win_dur;
        cnt_clear = 1'b1;
        state_nx  = (win_dur == '0) ? DONE : RUN;
      end
      RUN: begin
        busy       = 1'b1;
        grant      = win_oh;
        cnt_max    = win_dur;
        cnt_enable = 1'b1;
        if (cnt_ready) state_nx = DONE;
`ifdef COUNT_SCHED_TIMEOUT_EN
        else if (timeout) state_nx = IDLE;
`endif
      end
      DONE: begin
        busy     = 1'b1;
        grant    = win_oh;
        cnt_max  = win_dur;
        done     = win_oh;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: vector table of single services plus multi-cycle sequences.
// The bench owns the shared counter; its ready marks the dur-th enabled cycle.
module tb_count_sched;

  logic        clk;
  logic        nrst;
  logic [3:0]  req;
  logic [15:0] dur;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        err;
  logic        cnt_clear;
  logic        cnt_enable;
  logic [3:0]  cnt_max;
  logic        cnt_ready;

  int checks = 0;
  int errors = 0;

  count_sched #(.NREQ(4), .W(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req        (req),
    .dur        (dur),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .err        (err),
    .cnt_clear  (cnt_clear),
    .cnt_enable (cnt_enable),
    .cnt_max    (cnt_max),
    .cnt_ready  (cnt_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter: counts enabled cycles, ready during the cnt_max-th one and held.
  logic [3:0] tcnt;
  logic [3:0] max_m1;
  logic       ready_en;
  assign max_m1    = cnt_max - 4'd1;
  assign cnt_ready = ready_en && cnt_enable && (tcnt == max_m1);
  always_ff @(posedge clk) begin
    if (cnt_clear)                     tcnt <= '0;
    else if (cnt_enable && !cnt_ready) tcnt <= tcnt + 4'd1;
  end

  typedef struct {
    logic [3:0]  req;
    logic [15:0] dur;
    logic [3:0]  grant;
    logic [3:0]  max;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One service from IDLE. Latency counts edges from req until the edge that samples done.
  task automatic run_service(input logic [3:0] r, input logic [15:0] d, input logic [3:0] eg,
                             input logic [3:0] em, input int el, input bit drop_early,
                             input string tag);
    int n, ndone, nclr, nen, lat;
    bit seen;
    n = 0; ndone = 0; nclr = 0; nen = 0; lat = 0; seen = 0;
    req = r;
    dur = d;
    while (n < 64) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        dur = ~d;
        if (drop_early) req = '0;
      end
      if (busy) begin
        seen = 1'b1;
        chk($sformatf("%s grant", tag), grant, eg);
        chk($sformatf("%s cnt_max", tag), cnt_max, em);
        chk($sformatf("%s err", tag), err, 0);
        if (cnt_clear)  nclr++;
        if (cnt_enable) nen++;
      end
      if (done != '0) begin
        chk($sformatf("%s done", tag), done, eg);
        ndone++;
        lat = n + 1;
        req = '0;
      end
      if (seen && !busy) break;
    end
    chk($sformatf("%s finished", tag), seen && !busy, 1);
    chk($sformatf("%s done_count", tag), ndone, 1);
    chk($sformatf("%s clear_cycles", tag), nclr, 1);
    chk($sformatf("%s enable_cycles", tag), nen, em);
    chk($sformatf("%s latency", tag), lat, el);
  endtask

  // Held request(s): checks grant order at each LOAD, done per grant, one IDLE cycle between services.
  task automatic rr_seq(input logic [3:0] r, input logic [15:0] d, input logic [19:0] exp_pack,
                        input int cnt, input string tag);
    int k, nd, gap, n;
    logic [3:0] last_g, exp_g;
    bit prev_busy;
    k = 0; nd = 0; gap = 0; n = 0; last_g = '0; prev_busy = 1'b0;
    req = r;
    dur = d;
    while (nd < cnt && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (cnt_clear) begin
        exp_g = exp_pack[k*4 +: 4];
        chk($sformatf("%s grant%0d", tag, k), grant, exp_g);
        last_g = grant;
        if (k > 0) chk($sformatf("%s idle_gap%0d", tag, k), gap, 1);
        k++;
      end
      if (done != '0) begin
        chk($sformatf("%s done%0d", tag, nd), done, last_g);
        nd++;
        if (nd == cnt) req = '0;
      end
      if (!busy && prev_busy) gap = 0;
      if (!busy) gap++;
      prev_busy = busy;
    end
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("%s services", tag), k, cnt);
    chk($sformatf("%s dones", tag), nd, cnt);
    chk($sformatf("%s idle_after", tag), busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    bit saw_en;

    vecs[0] = '{4'b0001, 16'h0008, 4'b0001, 4'd8,  11};
    vecs[1] = '{4'b0100, 16'h5055, 4'b0100, 4'd0,  3};
    vecs[2] = '{4'b1011, 16'h5555, 4'b1000, 4'd5,  8};
    vecs[3] = '{4'b0110, 16'h0A70, 4'b0010, 4'd7,  10};
    vecs[4] = '{4'b0011, 16'h00F1, 4'b0001, 4'd1,  4};
    vecs[5] = '{4'b1111, 16'hF000, 4'b0010, 4'd0,  3};
    vecs[6] = '{4'b1000, 16'hF000, 4'b1000, 4'd15, 18};

    nrst = 1'b0;
    req = '0;
    dur = '0;
    ready_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset grant", grant, 0);
    chk("reset done", done, 0);
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);
    chk("reset cnt_clear", cnt_clear, 0);
    chk("reset cnt_enable", cnt_enable, 0);
    chk("reset cnt_max", cnt_max, 0);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_service(vecs[i].req, vecs[i].dur, vecs[i].grant, vecs[i].max, vecs[i].lat, 1'b0,
                  $sformatf("vec%0d", i));

    run_service(4'b0001, 16'h0003, 4'b0001, 4'd3, 6, 1'b1, "drop_req");

    // Asynchronous reset in the middle of RUN.
    req = 4'b0001;
    dur = 16'h0008;
    n = 0;
    saw_en = 1'b0;
    while (n < 20 && !saw_en) begin
      @(posedge clk); #1;
      n++;
      saw_en = cnt_enable;
    end
    chk("midrun reached_run", saw_en, 1);
    repeat (2) @(posedge clk);
    #2;
    nrst = 1'b0;
    req = '0;
    #1;
    chk("midrun grant", grant, 0);
    chk("midrun cnt_enable", cnt_enable, 0);
    chk("midrun busy", busy, 0);
    chk("midrun done", done, 0);
    chk("midrun err", err, 0);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;

    rr_seq(4'b1111, 16'h2222, {4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001}, 5, "rr_all");
    run_service(4'b0001, 16'h0008, 4'b0001, 4'd8, 11, 1'b0, "after_reset");
    rr_seq(4'b0100, 16'h1111, {4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100}, 3, "rr_single");

`ifdef COUNT_SCHED_TIMEOUT_EN
    begin
      int nerr, nen, ndone;
      nerr = 0; nen = 0; ndone = 0;
      ready_en = 1'b0;
      req = 4'b0001;
      dur = 16'h0005;
      n = 0;
      while (n < 80 && nerr == 0) begin
        @(posedge clk); #1;
        n++;
        if (cnt_enable) nen++;
        if (done != '0) ndone++;
        if (err) begin
          nerr++;
          req = '0;
          chk("timeout busy_at_err", busy, 0);
        end
      end
      repeat (4) begin
        @(posedge clk); #1;
        if (err) nerr++;
        if (done != '0) ndone++;
      end
      chk("timeout err_pulses", nerr, 1);
      chk("timeout run_cycles", nen, 40);
      chk("timeout done", ndone, 0);
      chk("timeout busy_end", busy, 0);
      ready_en = 1'b1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001: Parameter NREQ, default 4, number of requesters.
REQ-002: Parameter W, default 4, counter and duration width in bits.
REQ-003: clk  input  1  system clock, rising-edge.
REQ-004: nrst  input  1  asynchronous active-low reset.
REQ-005: req  input  NREQ  per-requester service request, level.
REQ-006: dur  input  NREQ*W  packed durations; requester i uses bits [i*W +: W].
REQ-007: grant  output  NREQ  one-hot owner of the shared counter; all zero when idle.
REQ-008: done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-009: busy  output  1  high in any state other than IDLE.
REQ-010: err  output  1  one-cycle timeout pulse; see Configuration.
REQ-011: cnt_clear  output  1  synchronous clear to the shared counter.
REQ-012: cnt_enable  output  1  count enable to the shared counter.
REQ-013: cnt_max  output  W  terminal value to the shared counter.
REQ-014: cnt_ready  input  1  counter reached cnt_max; held while enabled.

Function
REQ-015: The block shall implement the FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-016: In IDLE with any req bit high, the block shall select a winner round-robin, starting from the index after the last served requester, and enter LOAD next cycle.
REQ-017: In LOAD, the block shall assert cnt_clear for exactly one cycle, drive cnt_max with the winner's dur latched at selection, and assert grant for the winner.
REQ-018: A winner duration of 0 shall skip RUN: LOAD -> DONE directly, with cnt_enable never asserted.
REQ-019: In RUN, the block shall hold cnt_enable high until cnt_ready is sampled high, then enter DONE.
REQ-020: In DONE, the block shall pulse done for the winner for one cycle, deassert cnt_enable, and return to IDLE.
REQ-021: grant and cnt_max shall stay stable from LOAD through DONE inclusive.
REQ-022: Deasserting the winner's req after selection shall not abort service; done still pulses.
REQ-023: The block shall ignore changes to dur after selection.
REQ-024: Requests arriving outside IDLE shall wait; a held request is guaranteed service within NREQ services.
REQ-025: Minimum latency from req high in IDLE to done shall be 3 cycles for dur=0 and dur+3 cycles otherwise, given a counter that asserts ready one cycle after reaching max.
REQ-026: The round-robin pointer shall update to the winner index on entry to LOAD.
REQ-027: With a single requester held high, the block shall re-grant it every service, passing through IDLE for one cycle between services.

Reset
REQ-028: nrst low shall asynchronously force IDLE, round-robin pointer to NREQ-1 (index 0 has first priority), and all outputs to 0.
REQ-029: Reset during RUN shall drop cnt_enable and grant immediately, with no done or err pulse.

Configuration
REQ-030: With macro COUNT_SCHED_TIMEOUT_EN defined, a 6-bit watchdog shall count RUN cycles; on reaching 40 without cnt_ready, the block shall pulse err, skip done, deassert cnt_enable, and return to IDLE.
REQ-031: Without COUNT_SCHED_TIMEOUT_EN, RUN shall wait indefinitely, err shall be tied to 0, and no watchdog logic shall exist.

Verification
REQ-032: Reset, then req=0001, dur0=8 -> grant=0001 during LOAD/RUN/DONE, cnt_max=8, done=0001 pulse 11 cycles after req.
REQ-033: req=1111 held, all dur=2 -> grants in order 0001, 0010, 0100, 1000, 0001; each done pulses once per grant.
REQ-034: req=0100, dur2=0 -> LOAD then DONE; cnt_enable stays 0; done=0100 three cycles after req.
REQ-035: Assert nrst=0 mid-RUN with dur=8 -> grant, cnt_enable, and busy go to 0 asynchronously; no done; the next req=0001 is served normally.
REQ-036: COUNT_SCHED_TIMEOUT_EN defined, cnt_ready tied 0, req=0001 dur=5 -> err pulses once after 40 RUN cycles, done stays 0, busy returns to 0.
REQ-037: req0 dropped one cycle after selection, dur0=3 -> service completes and done=0001 still pulses.
